// File: rtl/accum4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : accum4_sequencer (with full_adder leaf cell)
//  Description : Multi-cycle burst accumulator. Accepts LEN operands over a
//                valid/ready stream and feeds each one, together with the
//                running sum, through a structural ripple chain of full_adder
//                cells. Presents the final sum and a sticky overflow flag on
//                an output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  full_adder : single-bit full adder cell, one link of the ripple chain
// ----------------------------------------------------------------------------
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_s    = w_axb ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule

// ----------------------------------------------------------------------------
//  accum4_sequencer : IDLE -> ACCUM -> DONE burst accumulator
// ----------------------------------------------------------------------------
module accum4_sequencer #(
   parameter int WIDTH = 4,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_sum,
   output logic             o_out_carry,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [LEN_W-1:0] r_remaining;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_sum;
   logic             r_out_carry;
   logic             r_busy;

   // Ripple chain: carry enters at the LSB as 0, carry-out leaves the MSB.
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_beat;
   logic             w_carry_nxt;

   assign w_c[0] = 1'b0;

   generate
      for (genvar g = 0; g < WIDTH; g++) begin : g_ripple
         full_adder u_fa (
            .i_a    (r_acc[g]),
            .i_b    (i_in_data[g]),
            .i_cin  (w_c[g]),
            .o_s    (w_sum[g]),
            .o_cout (w_c[g+1])
         );
      end
   endgenerate

   assign w_cout      = w_c[WIDTH];
   assign w_beat      = i_in_valid & r_in_ready;
   assign w_carry_nxt = r_carry | w_cout;

   // State machine with registered handshake/result outputs; each output
   // register is loaded together with the state it belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_remaining <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_carry <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_acc       <= '0;
                  r_carry     <= 1'b0;
                  r_remaining <= i_len;
                  r_busy      <= 1'b1;
                  if (i_len != c_LEN_ZERO) begin
                     r_state    <= S_ACCUM;
                     r_in_ready <= 1'b1;
                  end else begin
                     // Empty burst: result is an immediate zero sum.
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_out_sum   <= '0;
                     r_out_carry <= 1'b0;
                  end
               end
            end

            S_ACCUM: begin
               if (w_beat) begin
                  r_acc       <= w_sum;
                  r_carry     <= w_carry_nxt;
                  r_remaining <= r_remaining - c_LEN_ONE;
                  if (r_remaining == c_LEN_ONE) begin
                     // Last operand: result goes out next cycle, taken
                     // straight from the adder so no extra stage is added.
                     r_state     <= S_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_sum   <= w_sum;
                     r_out_carry <= w_carry_nxt;
                  end
               end
            end

            S_DONE: begin
               if (i_out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_out_sum;
   assign o_out_carry = r_out_carry;
   assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_accum4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum4_sequencer
//  Description : Directed self-checking bench for accum4_sequencer with an
//                expected-result scoreboard drained by an output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum4_sequencer;

   logic       clk;
   logic       rst;
   logic       i_start;
   logic [2:0] i_len;
   logic       i_in_valid;
   logic       o_in_ready;
   logic [3:0] i_in_data;
   logic       o_out_valid;
   logic       i_out_ready;
   logic [3:0] o_out_sum;
   logic       o_out_carry;
   logic       o_busy;

   typedef struct {
      logic [3:0] sum;
      logic       carry;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   accum4_sequencer #(.WIDTH(4), .LEN_W(3)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_len       (i_len),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_sum   (o_out_sum),
      .o_out_carry (o_out_carry),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops the scoreboard on every output handshake and checks that a held
   // result stays stable while the consumer stalls.
   logic       hold_pend = 1'b0;
   logic [3:0] held_sum;
   logic       held_carry;
   always @(negedge clk) begin
      if (!rst) begin
         if (hold_pend) begin
            chk("hold_valid", 32'(o_out_valid), 32'd1);
            chk("hold_sum",   32'(o_out_sum),   32'(held_sum));
            chk("hold_carry", 32'(o_out_carry), 32'(held_carry));
         end
         if (o_out_valid && i_out_ready) begin
            n_checks++;
            assert (q_exp.size() > 0) else begin
               n_errors++;
               $error("FAIL sb_unexpected observed=result expected=none");
            end
            if (q_exp.size() > 0) begin
               exp_t e;
               e = q_exp.pop_front();
               chk("sb_sum",   32'(o_out_sum),   32'(e.sum));
               chk("sb_carry", 32'(o_out_carry), 32'(e.carry));
            end
         end
         hold_pend  = o_out_valid && !i_out_ready;
         held_sum   = o_out_sum;
         held_carry = o_out_carry;
      end else begin
         hold_pend = 1'b0;
      end
   end

   task automatic start_burst(input int n);
      i_start = 1'b1;
      i_len   = 3'(n);
      tick();
      i_start = 1'b0;
      chk("start_in_ready", 32'(o_in_ready), (n != 0) ? 32'd1 : 32'd0);
      chk("start_busy",     32'(o_busy),     32'd1);
   endtask

   task automatic send_beat(input logic [3:0] d);
      bit done;
      done       = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = d;
      for (int k = 0; k < 20 && !done; k++) begin
         if (o_in_ready === 1'b1) done = 1'b1;
         tick();
      end
      if (!done) chk("beat_timeout", 32'(o_in_ready), 32'd1);
      i_in_valid = 1'b0;
   endtask

   task automatic drain(input int hold);
      if (hold > 0) begin
         i_out_ready = 1'b0;
         repeat (hold) tick();
      end
      i_out_ready = 1'b1;
      tick();
      chk("drain_valid", 32'(o_out_valid), 32'd0);
      chk("drain_busy",  32'(o_busy),      32'd0);
   endtask

   // Complete burst: model result pushed, beats sent with gaps, latency
   // checked, result drained after 'hold' stalled cycles.
   task automatic run_burst(input int n, input logic [27:0] d, input int gap, input int hold);
      exp_t       e;
      logic [4:0] s5;
      logic [3:0] acc;
      logic       cy;
      acc = 4'd0;
      cy  = 1'b0;
      for (int i = 0; i < n; i++) begin
         s5  = {1'b0, acc} + {1'b0, d[4*i +: 4]};
         acc = s5[3:0];
         cy  = cy | s5[4];
      end
      e.sum   = acc;
      e.carry = cy;
      q_exp.push_back(e);
      if (hold > 0) i_out_ready = 1'b0;
      start_burst(n);
      for (int i = 0; i < n; i++) begin
         send_beat(d[4*i +: 4]);
         if (i != n - 1) repeat (gap) tick();
      end
      chk("latency_valid",    32'(o_out_valid), 32'd1);
      chk("done_in_ready",    32'(o_in_ready),  32'd0);
      drain(hold);
   endtask

   initial begin
      exp_t e;
      rst         = 1'b1;
      i_start     = 1'b0;
      i_len       = 3'd0;
      i_in_valid  = 1'b0;
      i_in_data   = 4'd0;
      i_out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_in_ready",  32'(o_in_ready),  32'd0);
      chk("rst_out_valid", 32'(o_out_valid), 32'd0);
      chk("rst_out_sum",   32'(o_out_sum),   32'd0);
      chk("rst_out_carry", 32'(o_out_carry), 32'd0);
      chk("rst_busy",      32'(o_busy),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 1: 2+3+4 back to back
      run_burst(3, 28'h0000432, 0, 0);
      // 2: 9+8 wraps with carry, then 3+4 clears the sticky flag
      run_burst(2, 28'h0000089, 0, 0);
      run_burst(2, 28'h0000043, 0, 0);
      // 3: empty burst
      run_burst(0, 28'h0000000, 0, 0);
      // 4: gaps between beats, consumer stalls 4 cycles
      run_burst(3, 28'h0000321, 2, 4);
      // wrap over several beats: 15*7 = 105 -> 9, carry
      run_burst(7, 28'hFFFFFFF, 1, 1);

      // 5: start during ACCUM and in_valid during DONE are ignored
      e.sum   = 4'd11;
      e.carry = 1'b0;
      q_exp.push_back(e);
      start_burst(2);
      send_beat(4'd5);
      i_start = 1'b1;
      i_len   = 3'd7;
      tick();
      i_start = 1'b0;
      chk("restart_ignored_busy", 32'(o_busy), 32'd1);
      send_beat(4'd6);
      chk("t5_latency_valid", 32'(o_out_valid), 32'd1);
      i_out_ready = 1'b0;
      i_in_valid  = 1'b1;
      i_in_data   = 4'd15;
      tick();
      tick();
      chk("done_no_consume_ready", 32'(o_in_ready), 32'd0);
      chk("done_sum_held",         32'(o_out_sum),  32'd11);
      i_in_valid = 1'b0;
      drain(0);

      // 6: asynchronous reset mid-burst, then a fresh burst
      start_burst(4);
      send_beat(4'd1);
      send_beat(4'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready",  32'(o_in_ready),  32'd0);
      chk("arst_out_valid", 32'(o_out_valid), 32'd0);
      chk("arst_busy",      32'(o_busy),      32'd0);
      chk("arst_out_sum",   32'(o_out_sum),   32'd0);
      chk("arst_out_carry", 32'(o_out_carry), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      run_burst(1, 28'h000000F, 0, 0);

      repeat (2) tick();
      chk("sb_empty", 32'(q_exp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
